// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings for the iterative divider
//
// Purpose: op encodings (RV32M funct3[1:0]) and FSM state constants
//          shared by iterative_divider_32 and its helpers.
// Ports:   none (package).

package div_pkg;

  // funct3[1:0] of the RV32M divide group.
  // Bit 0 set means unsigned; bit 1 set means the remainder is returned.
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
  localparam logic [STATE_W-1:0] ST_FIX  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Purpose: shifts {rem,quot} left by one, trial-subtracts the divisor and
//          either keeps the difference (quotient bit 1) or restores (bit 0).
// Ports:
//   rem_in    in   XLEN+1  partial remainder
//   quot_in   in   XLEN    dividend bits still to shift in / quotient so far
//   divisor   in   XLEN    divisor magnitude
//   rem_out   out  XLEN+1  next partial remainder
//   quot_out  out  XLEN    next quotient register

module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quot_out
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // One extra bit on top so the borrow of the trial subtraction is visible.
  assign shifted = {rem_in, quot_in[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor};

  always_comb begin
    rem_out  = shifted[XLEN:0];
    quot_out = {quot_in[XLEN-2:0], 1'b0};
    if (!diff[XLEN+1]) begin
      rem_out  = diff[XLEN:0];
      quot_out = {quot_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iterative_divider_32.sv
// rtl/iterative_divider_32.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose: accepts one operation per start pulse in IDLE, iterates XLEN
//          cycles, fixes signs, and presents the result with a one-cycle
//          done pulse. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request, sampled only in IDLE
//   flush   in   1     synchronous abort of the in-flight op
//   op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   src1    in   XLEN  dividend
//   src2    in   XLEN  divisor
//   busy    out  1     op in flight (CALC or FIX)
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  quotient or remainder, held until overwritten

import div_pkg::*;

module iterative_divider_32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cnt;
  logic [XLEN:0]      rem_r;
  logic [XLEN-1:0]    quot_r;
  logic [XLEN-1:0]    divisor_r;
  logic               rem_sel;
  logic               neg_q;
  logic               neg_r;

  logic               is_signed;
  logic               src1_neg;
  logic               src2_neg;
  logic [XLEN-1:0]    mag1;
  logic [XLEN-1:0]    mag2;
  logic               div_by_zero;
  logic               overflow;

  logic [XLEN:0]      step_rem;
  logic [XLEN-1:0]    step_quot;
  logic [XLEN-1:0]    fix_q;
  logic [XLEN-1:0]    fix_r;

  assign is_signed   = (op[0] == DIV_OP_DIV[0]);
  assign src1_neg    = is_signed & src1[XLEN-1];
  assign src2_neg    = is_signed & src2[XLEN-1];
  // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
  assign mag1        = src1_neg ? (~src1 + 1'b1) : src1;
  assign mag2        = src2_neg ? (~src2 + 1'b1) : src2;
  assign div_by_zero = (src2 == '0);
  assign overflow    = is_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in   (rem_r),
    .quot_in  (quot_r),
    .divisor  (divisor_r),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  assign fix_q = neg_q ? (~quot_r + 1'b1) : quot_r;
  assign fix_r = neg_r ? (~rem_r[XLEN-1:0] + 1'b1) : rem_r[XLEN-1:0];

  assign busy = (state == ST_CALC) || (state == ST_FIX);
  // A flush landing on the DONE cycle squashes the pulse as well.
  assign done = (state == ST_DONE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      quot_r    <= '0;
      divisor_r <= '0;
      rem_sel   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            rem_sel <= op[1];
            neg_q   <= (src1_neg ^ src2_neg) & !div_by_zero;
            neg_r   <= src1_neg;
            if (div_by_zero) begin
              result <= op[1] ? src1 : '1;
              state  <= ST_DONE;
            end else if (overflow) begin
              result <= op[1] ? '0 : src1;
              state  <= ST_DONE;
            end else begin
              quot_r    <= mag1;
              divisor_r <= mag2;
              rem_r     <= '0;
              cnt       <= CNT_W'(XLEN-1);
              state     <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            rem_r  <= step_rem;
            quot_r <= step_quot;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            result <= rem_sel ? fix_r : fix_q;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
